// File: rtl/stage2_out_collector_if.sv
// Handshake bundle between the stage-2 pooled-pixel source, the frame collector
// and whatever consumes the serialised word stream.
interface stage2_out_collector_if #(
  parameter int Datawidth = 32,
  parameter int PIX_W     = 6
);
  logic                 valid_in;
  logic [Datawidth-1:0] In_0, In_1, In_2, In_3, In_4, In_5;
  logic [Datawidth-1:0] In_6, In_7, In_8, In_9, In_10, In_11;
  logic                 out_ready;
  logic                 out_valid;
  logic [Datawidth-1:0] out_data;
  logic [3:0]           out_ch;
  logic [PIX_W-1:0]     out_pix;
  logic                 out_last;
  logic                 frame_done;
  logic                 busy;
  logic                 overflow;

  modport slave (
    input  valid_in, In_0, In_1, In_2, In_3, In_4, In_5,
           In_6, In_7, In_8, In_9, In_10, In_11, out_ready,
    output out_valid, out_data, out_ch, out_pix, out_last,
           frame_done, busy, overflow
  );

  modport master (
    output valid_in, In_0, In_1, In_2, In_3, In_4, In_5,
           In_6, In_7, In_8, In_9, In_10, In_11, out_ready,
    input  out_valid, out_data, out_ch, out_pix, out_last,
           frame_done, busy, overflow
  );
endinterface

// File: rtl/stage2_out_collector.sv
// Captures one pooled 12-channel frame into a local buffer, then replays it
// one channel word per beat under valid/ready.
module stage2_out_collector #(
  parameter int IMG_Width  = 14,
  parameter int IMG_Height = 14,
  parameter int Datawidth  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  stage2_out_collector_if.slave  bus
);
  localparam int PW    = IMG_Width / 2;
  localparam int PH    = IMG_Height / 2;
  localparam int N     = PW * PH;
  localparam int NCH   = 12;
  localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N - 1);
  localparam logic [3:0]       LAST_CH  = 4'd11;
  localparam bit               BYPASS   = (N == 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t               state_q;
  logic [PIX_W-1:0]     wcnt_q;
  logic [PIX_W-1:0]     rpix_q, rpix_d;
  logic [3:0]           rch_q, rch_d;
  logic                 out_valid_q, out_last_q, frame_done_q, overflow_q;
  logic [Datawidth-1:0] out_data_q;
  logic [Datawidth-1:0] in_arr [NCH];
  logic [Datawidth-1:0] mem [N][NCH];
  logic                 wr_en;

  assign in_arr[0]  = bus.In_0;
  assign in_arr[1]  = bus.In_1;
  assign in_arr[2]  = bus.In_2;
  assign in_arr[3]  = bus.In_3;
  assign in_arr[4]  = bus.In_4;
  assign in_arr[5]  = bus.In_5;
  assign in_arr[6]  = bus.In_6;
  assign in_arr[7]  = bus.In_7;
  assign in_arr[8]  = bus.In_8;
  assign in_arr[9]  = bus.In_9;
  assign in_arr[10] = bus.In_10;
  assign in_arr[11] = bus.In_11;

  assign wr_en = (state_q == FILL) && bus.valid_in;

  // Read-index advance: channel is the fast index, pixel steps on channel wrap.
  always_comb begin
    rch_d  = rch_q + 4'd1;
    rpix_d = rpix_q;
    if (rch_q == LAST_CH) begin
      rch_d  = 4'd0;
      rpix_d = rpix_q + PIX_W'(1);
    end
  end

  // Frame buffer carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < NCH; c++) begin
        mem[wcnt_q][c] <= in_arr[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wcnt_q       <= '0;
      rpix_q       <= '0;
      rch_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (bus.valid_in) begin
            if (wcnt_q == LAST_PIX) begin
              wcnt_q      <= '0;
              rpix_q      <= '0;
              rch_q       <= '0;
              state_q     <= DRAIN;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              // With a single-pixel frame, pixel 0 is still in flight into the buffer.
              out_data_q  <= BYPASS ? in_arr[0] : mem[0][0];
            end else begin
              wcnt_q <= wcnt_q + PIX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.valid_in) overflow_q <= 1'b1;
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q      <= FILL;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              frame_done_q <= 1'b1;
              rpix_q       <= '0;
              rch_q        <= '0;
            end else begin
              rch_q      <= rch_d;
              rpix_q     <= rpix_d;
              out_data_q <= mem[rpix_d][rch_d];
              out_last_q <= (rpix_d == LAST_PIX) && (rch_d == LAST_CH);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = rch_q;
  assign bus.out_pix    = rpix_q;
  assign bus.out_last   = out_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_stage2_out_collector.sv
// Directed bench for stage2_out_collector: fill, drain, backpressure, gaps,
// overflow, asynchronous reset mid-drain and back-to-back frames.
module tb_stage2_out_collector;
  localparam int NPIX  = 49;
  localparam int NWORD = NPIX * 12;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  stage2_out_collector_if #(.Datawidth(32), .PIX_W(6)) bus ();

  stage2_out_collector #(.IMG_Width(14), .IMG_Height(14), .Datawidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [7:0] tag, input int p, input int c);
    return {tag, 8'h00, 8'(p), 8'(c)};
  endfunction

  task automatic set_pix(input logic [7:0] tag, input int p);
    bus.In_0  = word(tag, p, 0);  bus.In_1  = word(tag, p, 1);
    bus.In_2  = word(tag, p, 2);  bus.In_3  = word(tag, p, 3);
    bus.In_4  = word(tag, p, 4);  bus.In_5  = word(tag, p, 5);
    bus.In_6  = word(tag, p, 6);  bus.In_7  = word(tag, p, 7);
    bus.In_8  = word(tag, p, 8);  bus.In_9  = word(tag, p, 9);
    bus.In_10 = word(tag, p, 10); bus.In_11 = word(tag, p, 11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Feeds one frame with 'gap' idle cycles between pixels; returns at the
  // negedge after the edge that sampled the last pixel.
  task automatic fill_frame(input logic [7:0] tag, input int gap);
    for (int p = 0; p < NPIX; p++) begin
      set_pix(tag, p);
      bus.valid_in = 1'b1;
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (p < NPIX - 1) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
          errors++;
          $display("FAIL fill_idle p=%0d out_valid=%b frame_done=%b expected 0 0", p, bus.out_valid, bus.frame_done);
        end
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_gap p=%0d out_valid=%b expected 0", p, bus.out_valid);
          end
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_pix !== 6'd0 ||
        bus.out_ch !== 4'd0 || bus.out_data !== word(tag, 0, 0)) begin
      errors++;
      $display("FAIL fill_latency valid=%b busy=%b pix=%0d ch=%0d data=%h expected 1 1 0 0 %h",
               bus.out_valid, bus.busy, bus.out_pix, bus.out_ch, bus.out_data, word(tag, 0, 0));
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1.
  task automatic drain_frame(input logic [7:0] tag, input int mode, input bit inject, input bit b2b);
    int idx = 0;
    int cyc = 0;
    int ep, ec;
    bit rdy;
    while (idx < NWORD && cyc < 4000) begin
      ep = idx / 12;
      ec = idx % 12;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_data !== word(tag, ep, ec) ||
          bus.out_ch !== 4'(ec) || bus.out_pix !== 6'(ep) || bus.out_last !== (idx == NWORD - 1)) begin
        errors++;
        $display("FAIL drain_word idx=%0d got v=%b data=%h ch=%0d pix=%0d last=%b expected 1 %h %0d %0d %b",
                 idx, bus.out_valid, bus.out_data, bus.out_ch, bus.out_pix, bus.out_last,
                 word(tag, ep, ec), ec, ep, (idx == NWORD - 1));
      end
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      bus.out_ready = rdy;
      if (inject && cyc >= 3 && cyc < 6) begin
        bus.valid_in = 1'b1;
        bus.In_0     = 32'hDEADBEEF;
      end else begin
        bus.valid_in = 1'b0;
      end
      if (rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (idx < NWORD) begin
      errors++;
      $display("FAIL drain_timeout words=%0d expected %0d", idx, NWORD);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_last !== 1'b0 || bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_end valid=%b busy=%b last=%b done=%b expected 0 0 0 1",
               bus.out_valid, bus.busy, bus.out_last, bus.frame_done);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != NWORD) begin
        errors++;
        $display("FAIL drain_cycles got %0d expected %0d", cyc, NWORD);
      end
    end
    if (!b2b) begin
      @(negedge clk);
      checks++;
      if (bus.frame_done !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse done=%b valid=%b expected 0 0", bus.frame_done, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    set_pix(8'h00, 0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_ch !== 4'd0 || bus.out_pix !== 6'd0 ||
        bus.out_last !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%h ch=%0d pix=%0d last=%b done=%b busy=%b ovf=%b expected all 0",
               bus.out_valid, bus.out_data, bus.out_ch, bus.out_pix, bus.out_last,
               bus.frame_done, bus.busy, bus.overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_frame(8'h01, 0);
    drain_frame(8'h01, 0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_overflow got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_backpressure();
    fill_frame(8'h02, 0);
    drain_frame(8'h02, 1, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    fill_frame(8'h01, 2);
    drain_frame(8'h01, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    fill_frame(8'h06, 0);
    drain_frame(8'h06, 0, 1'b1, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got %b expected 1", bus.overflow);
    end
    fill_frame(8'h07, 0);
    drain_frame(8'h07, 0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b expected 1", bus.overflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    do_reset();
    fill_frame(8'h03, 0);
    bus.out_ready = 1'b1;
    bus.valid_in  = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_overflow got %b expected 1", bus.overflow);
    end
    while (bus.out_pix !== 6'd20 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_pix !== 6'd20) begin
      errors++;
      $display("FAIL mid_reach_pix20 got %0d expected 20", bus.out_pix);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.out_pix !== 6'd0) begin
      errors++;
      $display("FAIL async_reset valid=%b busy=%b ovf=%b pix=%0d expected 0 0 0 0",
               bus.out_valid, bus.busy, bus.overflow, bus.out_pix);
    end
    @(negedge clk);
    rst = 1'b0;
    fill_frame(8'h04, 0);
    drain_frame(8'h04, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_frame(8'h08, 0);
    drain_frame(8'h08, 0, 1'b0, 1'b1);
    fill_frame(8'h09, 0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow got %b expected 0", bus.overflow);
    end
    drain_frame(8'h09, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_overflow();
    test_reset_mid_drain();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
